// File: rtl/shared_mem_responder.sv
// Single-ported word memory shared by the CPU fetch and data ports.
// Round-robin arbitration on ties, programmable wait states, one-cycle ack.
module shared_mem_responder #(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: an initiator holds req (and its address/data) high until it
  // sees its ack; ack is a one-cycle pulse and requests are sampled only in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    last_dm_q, last_dm_d;
  logic                    gnt_dm_q, gnt_dm_d;
  logic                    we_q, we_d;
  logic                    mis_q, mis_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             if_rdata_q, if_rdata_d;
  logic [31:0]             dm_rdata_q, dm_rdata_d;

  logic        any_req;
  logic        pick_dm;
  logic        do_op;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], dm_addr[31:ADDR_WIDTH+2]};

  assign any_req = if_req | dm_req;
  // On a tie the port that lost last time wins, so neither port can starve.
  assign pick_dm = dm_req & (~if_req | ~last_dm_q);
  assign do_op   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign rd_word = mis_q ? 32'h0 : mem[idx_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_dm_q  <= 1'b0;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Reset forces IDLE, so a write still counting down is never committed.
  always_ff @(posedge clock) begin
    if (do_op && gnt_dm_q && we_q && !mis_q) mem[idx_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    mis_d      = mis_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (state_q == IDLE && any_req) begin
      gnt_dm_d  = pick_dm;
      last_dm_d = pick_dm;
      we_d      = pick_dm & dm_we;
      idx_d     = pick_dm ? dm_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
      mis_d     = pick_dm ? (dm_addr[1:0] != 2'b00) : (if_addr[1:0] != 2'b00);
      wdata_d   = dm_wdata;
      cnt_d     = 4'(WAIT_STATES);
    end else if (state_q == ACCESS && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (do_op && !we_q) begin
      if (gnt_dm_q) dm_rdata_d = rd_word;
      else          if_rdata_d = rd_word;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    if_ack    = (state_q == RESP) && !gnt_dm_q;
    dm_ack    = (state_q == RESP) &&  gnt_dm_q;
    err       = (state_q == RESP) &&  mis_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Bench for shared_mem_responder: three instances (W=1, W=3, W=0) sharing
// clock and reset, one scoreboard queue checked whenever any ack fires.
module tb_shared_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req   [3];
  logic [31:0] if_addr  [3];
  logic        if_ack   [3];
  logic [31:0] if_rdata [3];
  logic        dm_req   [3];
  logic        dm_we    [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];
  logic        dm_ack   [3];
  logic [31:0] dm_rdata [3];
  logic        busy     [3];
  logic        err      [3];
  logic [1:0]  dbg_state[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shared_mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clock    (clk),
      .reset    (rst),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ack   (if_ack[g]),
      .if_rdata (if_rdata[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_ack   (dm_ack[g]),
      .dm_rdata (dm_rdata[g]),
      .busy     (busy[g]),
      .err      (err[g]),
      .dbg_state(dbg_state[g])
    );
  end

  // Scoreboard entry: {instance[1:0], is_data_port, err, rdata[31:0]}
  logic [35:0] exp_q[$];
  int          ack_cyc_q[$];
  int          ack_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] model_mem[int];
  logic [31:0] model_dm[3];
  logic [31:0] model_if[3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input logic [35:0] got);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_ack", got, 36'hf_ffff_ffff);
    end else begin
      e = exp_q.pop_front();
      chk("sb_resp", got, e);
    end
    ack_cyc_q.push_back(cyc);
    ack_cnt++;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dm_ack[k] === 1'b1) sb_pop({2'(k), 1'b1, err[k], dm_rdata[k]});
      if (if_ack[k] === 1'b1) sb_pop({2'(k), 1'b0, err[k], if_rdata[k]});
    end
  end

  task automatic push_exp(input int k, input bit dm, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int          key;
    bit          mis;
    logic [31:0] val;
    key = k * 4096 + int'(addr[11:2]);
    mis = (addr[1:0] != 2'b00);
    if (dm && we) begin
      if (!mis) model_mem[key] = wdata;
      val = model_dm[k];
    end else begin
      val = mis ? 32'h0 : (model_mem.exists(key) ? model_mem[key] : 32'h0);
      if (dm) model_dm[k] = val;
      else    model_if[k] = val;
    end
    exp_q.push_back({2'(k), dm, mis, val});
  endtask

  task automatic access(input int k, input bit dm, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic ack_seen;
    push_exp(k, dm, we, addr, wdata);
    @(negedge clk);
    if (dm) begin
      dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    n = 0;
    ack_seen = 1'b0;
    while (!ack_seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) chk("busy_rise", 36'(busy[k]), 36'd1);
      ack_seen = dm ? dm_ack[k] : if_ack[k];
    end
    if (dm) dm_req[k] = 1'b0;
    else    if_req[k] = 1'b0;
    chk("ack_latency", 36'(n), 36'(ws_of(k) + 2));
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 36'(dm ? dm_ack[k] : if_ack[k]), 36'd0);
    chk("busy_fall", 36'(busy[k]), 36'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_dm[k] = 32'h0;
      model_if[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = 32'h0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = 32'h0; dm_wdata[k] = 32'h0;
      model_dm[k] = 32'h0; model_if[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 36'(busy[0]), 36'd0);
    chk("rst_ack", 36'({if_ack[0], dm_ack[0], err[0]}), 36'd0);
    chk("rst_rdata", 36'(if_rdata[0] | dm_rdata[0]), 36'd0);

    // Fetch of word 0 as the first access out of reset
    access(0, 1'b1, 1'b1, 32'h0, 32'h2008_0005);
    do_reset();
    access(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Data write then read of the same word
    access(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);

    // Both ports requesting from reset: data wins the first tie, then alternate
    do_reset();
    push_exp(0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_exp(0, 1'b0, 1'b0, 32'h0, 32'h0);
    push_exp(0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_exp(0, 1'b0, 1'b0, 32'h0, 32'h0);
    ack_cyc_q.delete();
    ack_cnt = 0;
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h10;
    n = 0;
    while (ack_cnt < 4 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    chk("tie_ack_count", 36'(ack_cnt), 36'd4);
    for (int i = 1; i < 4; i++) chk("tie_ack_gap", 36'(ack_cyc_q[i] - ack_cyc_q[i-1]), 36'd4);
    repeat (3) @(negedge clk);

    // Misaligned accesses: full timing, err with ack, no write, zero read data
    access(0, 1'b1, 1'b1, 32'h13, 32'h1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    access(0, 1'b1, 1'b0, 32'h12, 32'h0);
    access(0, 1'b0, 1'b0, 32'h2, 32'h0);

    // Randomised traffic over a small pre-written window
    for (int i = 0; i < 8; i++) access(0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 12; i++) begin
      bit dm_sel;
      bit we_sel;
      logic [31:0] a;
      dm_sel = 1'($urandom_range(0, 1));
      we_sel = dm_sel & 1'($urandom_range(0, 1));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      access(0, dm_sel, we_sel, a, $urandom);
    end

    // W=3: reset one cycle after a write is accepted abandons the write
    access(1, 1'b1, 1'b1, 32'h20, 32'h1111_1111);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 32'h20; dm_wdata[1] = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 36'(busy[1]), 36'd0);
    chk("midrst_ack_err", 36'({dm_ack[1], if_ack[1], err[1]}), 36'd0);
    chk("midrst_dm_rdata", 36'(dm_rdata[1]), 36'd0);
    chk("midrst_state", 36'(dbg_state[1]), 36'd0);
    dm_req[1] = 1'b0;
    dm_we[1]  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_dm[k] = 32'h0;
      model_if[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    access(1, 1'b1, 1'b0, 32'h20, 32'h0);

    // W=0 and address aliasing modulo 4 KiB
    access(2, 1'b1, 1'b1, 32'h0, 32'hCAFE_F00D);
    access(2, 1'b1, 1'b0, 32'h1000, 32'h0);
    access(2, 1'b0, 1'b0, 32'hFFFF_F000, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 36'(exp_q.size()), 36'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
